// File: rtl/hopfield_seq.sv
// rtl/hopfield_seq.sv - sequential Hopfield network: Hebbian learn, one-neuron-per-cycle recall
// Optional HOPFIELD_CONV_DETECT_EN: repeat sweeps until stable or MAXSW reached.
module hopfield_seq #(
  parameter int N     = 25,
  parameter int WW    = 4,
  parameter int MAXSW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         learn_valid,
  input  logic [N-1:0] learn_pattern,
  output logic         learn_ready,
  input  logic         start,
  input  logic [N-1:0] init_pattern,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [N-1:0] state_out,
  output logic [7:0]   sweeps
);

  localparam int KW = $clog2(N);
  localparam int AW = WW + KW + 1;
  localparam logic signed [WW-1:0] WMAX = WW'((1 << (WW - 1)) - 1);
  localparam logic signed [WW-1:0] WMIN = -WMAX;
`ifdef HOPFIELD_CONV_DETECT_EN
  localparam int SWLIM = MAXSW;
`else
  // Single sweep per start, never exceeding MAXSW.
  localparam int SWLIM = (MAXSW < 1) ? MAXSW : 1;
`endif

  typedef enum logic [1:0] {IDLE, LEARN, RECALL, FINISH} state_t;

  state_t               st, st_nx;
  logic signed [WW-1:0] w [N][N];
  logic [KW-1:0]        k;
  logic [N-1:0]         pat;
  logic                 chg;
  logic signed [AW-1:0] sum;
  logic                 nb;
  logic                 last_k;
  logic                 sweep_chg;
  logic                 stop;

  // Row k of the weight matrix dotted with the bipolar view of the live state.
  always_comb begin
    sum = '0;
    for (int m = 0; m < N; m++) begin
      if (state_out[m])
        sum = sum + {{(AW - WW){w[k][m][WW-1]}}, w[k][m]};
      else
        sum = sum - {{(AW - WW){w[k][m][WW-1]}}, w[k][m]};
    end
  end

  always_comb begin
    last_k    = (k == KW'(N - 1));
    nb        = (sum > 0) ? 1'b1 : (sum < 0) ? 1'b0 : state_out[k];
    sweep_chg = chg | (nb != state_out[k]);
`ifdef HOPFIELD_CONV_DETECT_EN
    stop      = !sweep_chg || (sweeps + 8'd1 == 8'(SWLIM));
`else
    stop      = (sweeps + 8'd1 == 8'(SWLIM));
`endif
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: begin
        if (clear)            st_nx = IDLE;
        else if (learn_valid) st_nx = LEARN;
        else if (start)       st_nx = RECALL;
      end
      LEARN:  if (last_k) st_nx = IDLE;
      RECALL: if (last_k && stop) st_nx = FINISH;
      FINISH: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign learn_ready = (st == IDLE);
  assign busy        = (st != IDLE);
  assign done        = (st == FINISH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= IDLE;
      k         <= '0;
      pat       <= '0;
      chg       <= 1'b0;
      state_out <= '0;
      sweeps    <= '0;
      converged <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w[i][j] <= '0;
    end else begin
      st <= st_nx;
      case (st)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                w[i][j] <= '0;
          end else if (learn_valid) begin
            pat <= learn_pattern;
            k   <= '0;
          end else if (start) begin
            state_out <= init_pattern;
            sweeps    <= '0;
            k         <= '0;
            chg       <= 1'b0;
            converged <= 1'b0;
          end
        end
        LEARN: begin
          // Diagonal is never written, so it stays at its cleared value of 0.
          for (int m = 0; m < N; m++) begin
            if (KW'(m) != k) begin
              if (pat[k] == pat[m])
                w[k][m] <= (w[k][m] == WMAX) ? w[k][m] : w[k][m] + WW'(1);
              else
                w[k][m] <= (w[k][m] == WMIN) ? w[k][m] : w[k][m] - WW'(1);
            end
          end
          k <= last_k ? '0 : k + KW'(1);
        end
        RECALL: begin
          state_out[k] <= nb;
          if (last_k) begin
            sweeps <= sweeps + 8'd1;
            k      <= '0;
            chg    <= 1'b0;
`ifdef HOPFIELD_CONV_DETECT_EN
            converged <= !sweep_chg;
`else
            converged <= 1'b0;
`endif
          end else begin
            k   <= k + KW'(1);
            chg <= sweep_chg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hopfield_seq.md
HOPFIELD_SEQ -- requirements
Module: hopfield_seq

Interface
REQ-001 Parameter N, default 25: number of neurons, 4..64.
REQ-002 Parameter WW, default 4: signed weight width, 3..8.
REQ-003 Parameter MAXSW, default 8: sweep limit, 1..255.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 clear  in  1  IDLE-only command: zero all weights.
REQ-007 learn_valid  in  1  learn request; learn_pattern is accepted when learn_valid and learn_ready are both high.
REQ-008 learn_pattern  in  N  bipolar pattern to store (1 = +1, 0 = -1).
REQ-009 learn_ready  out  1  high only in IDLE.
REQ-010 start  in  1  IDLE-only command: start recall from init_pattern.
REQ-011 init_pattern  in  N  recall seed, sampled when start is accepted.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle pulse when recall ends.
REQ-014 converged  out  1  valid with done; high if the last sweep changed no neuron.
REQ-015 state_out  out  N  current neuron vector, bit k = neuron k.
REQ-016 sweeps  out  8  completed sweeps of the last or current recall.

Function
REQ-017 FSM states: IDLE, LEARN, RECALL, FINISH.
REQ-018 IDLE command priority when several are high in one cycle: clear, then learn_valid, then start; lower-priority commands are ignored that cycle.
REQ-019 clear: every weight reads 0 on the next cycle; FSM stays in IDLE.
REQ-020 LEARN: latch the pattern; for N cycles process one row k = 0..N-1 per cycle.
REQ-021 LEARN row update: w[k][m] += +1 if p[k]==p[m], else -1, for all m != k.
REQ-022 LEARN arithmetic: saturate at ±(2^(WW-1)-1); w[k][k] stays 0; after row N-1, return to IDLE.
REQ-023 RECALL: load state_out from init_pattern; sweeps=0.
REQ-024 RECALL neuron update: one neuron per cycle, index k = 0..N-1.
REQ-025 RECALL sum: sum = Σm w[k][m]·s[m], with s = +1/-1, using the current state_out (asynchronous update).
REQ-026 RECALL rule: sum>0 sets 1, sum<0 sets 0, sum==0 keeps the old value.
REQ-027 Accumulator width: WW+clog2(N)+1 bits, signed; no overflow is possible.
REQ-028 End of sweep (k = N-1): sweeps increments; a per-sweep changed flag is recorded.
REQ-029 FINISH: done=1 for exactly one cycle; converged reflects the last sweep; then IDLE.
REQ-030 Weights persist across recalls; state_out holds its final value in IDLE.
REQ-031 learn_valid, start and clear have no effect while busy=1; no queueing.

Reset
REQ-032 rst=0 at a rising edge: FSM=IDLE, all weights 0, state_out=0, sweeps=0, done=0, converged=0, busy=0; learn_ready=1 from the first cycle after reset.
REQ-033 Reset asserted mid-LEARN or mid-RECALL aborts immediately and yields the REQ-032 values; no done pulse is produced.

Configuration
REQ-034 Macro HOPFIELD_CONV_DETECT_EN.
REQ-035 Defined: after each sweep, go to FINISH if the sweep changed no neuron or sweeps==MAXSW, else start a new sweep; converged = (last sweep unchanged).
REQ-036 Undefined: exactly one sweep per start, then FINISH; converged=0 always; MAXSW unused.

Verification (N=25, WW=4, MAXSW=8)
REQ-037 Reset, then clear, then start with init_pattern=25'h1FFFFFF: every sum is 0 and all neurons keep their value; done after 25 recall cycles; state_out=25'h1FFFFFF; converged=1 with macro, 0 without.
REQ-038 Learn 25'b0111010010100101001001111, then start with the same pattern: state_out unchanged; with macro, sweeps=1 and converged=1.
REQ-039 Learn the same pattern, then start with bits 0 and 7 flipped: with macro, state_out returns to the stored pattern, sweeps=2, converged=1.
REQ-040 Learn one pattern 9 times: all off-diagonal weights saturate at ±7 and never wrap; diagonal weights read 0.
REQ-041 Assert learn_valid, start and clear together in IDLE: only clear executes; busy stays 0.
REQ-042 Assert rst=0 at recall cycle 10: next cycle busy=0, state_out=0, no done pulse; a following learn is accepted, learn_ready=1.
